// File: rtl/mrd_sched_pkg.sv
// Shared types and constants for the two-engine packet scheduler.
package mrd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    BLOCK = 2'd2
  } state_t;

  localparam int TMO_W_DEF  = 12;
  localparam int ORDQ_DEPTH = 2;

endpackage

// File: rtl/mrd_sched_ordq.sv
// Two-entry FIFO of engine IDs recording the order in which packets were routed.
module mrd_sched_ordq
  import mrd_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  logic       mem [ORDQ_DEPTH];
  logic [1:0] cnt;
  logic       do_pop;
  logic       do_push;

  assign empty   = (cnt == 2'd0);
  assign full    = (cnt == 2'(ORDQ_DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      mem[0] <= 1'b0;
      mem[1] <= 1'b0;
    end else begin
      if (do_pop) begin
        mem[0] <= (do_push && cnt == 2'd1) ? din : mem[1];
        mem[1] <= (do_push && cnt == 2'd2) ? din : mem[1];
      end else if (do_push) begin
        if (cnt == 2'd0) mem[0] <= din;
        else             mem[1] <= din;
      end
      if (do_push && !do_pop)      cnt <= cnt + 2'd1;
      else if (!do_push && do_pop) cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: rtl/mrd_pkt_sched.sv
// Routes input packets to one of two DFT engines and tracks output order,
// dropping packets when no engine is free and aborting stalled ones.
module mrd_pkt_sched
  import mrd_sched_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int NENG  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic [5:0] in_size,
  output logic       in_ready,
  input  logic [1:0] eng_ready,
  input  logic [1:0] eng_src_eop,
  output logic       eng_sel,
  output logic [1:0] eng_sop,
  output logic [1:0] eng_valid,
  output logic [1:0] eng_abort,
  output logic       out_sel,
  output logic       out_en,
  output logic [5:0] size_q,
  output logic [7:0] drop_cnt
);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rr_ptr;
  logic             pick;
  logic             route_sel;
  logic             accept;
  logic             drop;
  logic             routing;
  logic             tmo_hit;
  logic             q_push;
  logic             q_pop;
  logic             q_full;
  logic             q_empty;
  logic [NENG-1:0]  sel_oh;

  assign in_ready = (state == IDLE) && (|eng_ready) && !q_full;

  // rr_ptr names the engine to prefer when both are free.
  always_comb begin
    pick = rr_ptr;
    if (eng_ready == 2'b01)      pick = 1'b0;
    else if (eng_ready == 2'b10) pick = 1'b1;
  end

  assign accept    = (state == IDLE) && in_valid && in_sop && in_ready;
  assign drop      = (state == IDLE) && in_valid && in_sop && !in_ready;
  assign routing   = accept || (state == ROUTE);
  assign route_sel = (state == IDLE) ? pick : eng_sel;
  assign sel_oh    = routing ? (NENG'(1) << route_sel) : '0;
  assign eng_sop   = {2{in_sop}} & sel_oh;
  assign eng_valid = {2{in_valid}} & sel_oh;

  assign tmo_hit = (state == ROUTE) && !(in_valid && in_eop) && (tmo_cnt == '1);
  assign q_push  = (accept && in_eop) || ((state == ROUTE) && in_valid && in_eop);
  assign q_pop   = out_en && eng_src_eop[out_sel];
  assign out_en  = !q_empty;

  mrd_sched_ordq u_ordq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .din   (route_sel),
    .head  (out_sel),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      eng_sel   <= 1'b0;
      size_q    <= 6'd0;
      drop_cnt  <= 8'd0;
      eng_abort <= 2'b00;
      tmo_cnt   <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      eng_abort <= 2'b00;
      if ((drop || tmo_hit) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            eng_sel <= pick;
            size_q  <= in_size;
            rr_ptr  <= ~pick;
            if (!in_eop) begin
              state   <= ROUTE;
              tmo_cnt <= TMO_W'(1);
            end
          end else if (drop && !in_eop) begin
            state <= BLOCK;
          end
        end
        ROUTE: begin
          if (in_valid && in_eop) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            eng_abort <= 2'b01 << eng_sel;
            state     <= IDLE;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        BLOCK: begin
          if (in_valid && in_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mrd_pkt_sched.md
MRD_PKT_SCHED -- requirements
Module: mrd_pkt_sched

Interface
REQ-001 SHALL have parameter TMO_W, default 12, width of the sink timeout counter.
REQ-002 SHALL have parameter NENG, default 2, number of DFT memory engines; the only supported value is 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-006 SHALL have port in_sop, input, 1 bit: first sample of a packet.
REQ-007 SHALL have port in_eop, input, 1 bit: last sample of a packet.
REQ-008 SHALL have port in_size, input, 6 bits: DFT size index, sampled at sop.
REQ-009 SHALL have port in_ready, output, 1 bit: the scheduler accepts a new sop.
REQ-010 SHALL have port eng_ready, input, 2 bits: per-engine sink_ready (engine FSM Idle).
REQ-011 SHALL have port eng_src_eop, input, 2 bits: per-engine last output sample.
REQ-012 SHALL have port eng_sel, output, 1 bit: engine receiving the current input packet.
REQ-013 SHALL have port eng_sop, output, 2 bits: one-hot sop gated to the selected engine.
REQ-014 SHALL have port eng_valid, output, 2 bits: one-hot valid gated to the selected engine.
REQ-015 SHALL have port eng_abort, output, 2 bits: one-cycle abort pulse to an engine.
REQ-016 SHALL have port out_sel, output, 1 bit: engine whose output is forwarded downstream.
REQ-017 SHALL have port out_en, output, 1 bit: the order queue is non-empty.
REQ-018 SHALL have port size_q, output, 6 bits: in_size latched for the packet in flight.
REQ-019 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped or aborted packets.

Function
REQ-020 SHALL implement FSM states IDLE, ROUTE and BLOCK.
REQ-021 In IDLE, SHALL drive in_ready = 1 iff any eng_ready bit is 1 and the order queue is not full.
REQ-022 In IDLE, an in_sop with in_valid and in_ready = 1 SHALL select an engine and move to ROUTE in the same cycle. Selection: the lowest-index ready engine; when both are ready, the engine not used last (round-robin).
REQ-023 An in_sop arriving while in_ready = 0 SHALL be dropped, SHALL increment drop_cnt, SHALL move the FSM to BLOCK, and SHALL raise no eng_sop.
REQ-024 eng_sop and eng_valid SHALL be combinational copies of in_sop and in_valid, masked to the one-hot bit of eng_sel, in the sop cycle and in every ROUTE cycle. Latency is 0.
REQ-025 In ROUTE, in_valid with in_eop SHALL push eng_sel into the order queue and return the FSM to IDLE on the next cycle.
REQ-026 In BLOCK, all samples SHALL be discarded until in_valid with in_eop; the FSM then returns to IDLE.
REQ-027 A sop and eop in the same cycle SHALL be treated as a one-sample packet: push and stay in IDLE.
REQ-028 In ROUTE, the timeout counter SHALL count cycles since sop. At 2^TMO_W-1 with no eop, the scheduler SHALL pulse eng_abort[eng_sel] for 1 cycle, increment drop_cnt, return to IDLE, and push nothing.
REQ-029 The order queue SHALL be a 2-entry FIFO of engine IDs. out_sel = head, and out_en = !empty.
REQ-030 eng_src_eop[out_sel] with out_en = 1 SHALL pop the head. eng_src_eop on the non-head engine, or with the queue empty, SHALL be ignored.
REQ-031 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order, including when the queue is full.
REQ-032 drop_cnt SHALL saturate at 255.
REQ-033 size_q SHALL load on an accepted sop and hold otherwise.

Reset
REQ-034 On rst_n = 0 at a clk edge, the scheduler SHALL go to IDLE and clear the queue.
REQ-035 On reset, the following outputs SHALL be 0: eng_sel, out_sel, out_en, size_q, drop_cnt, eng_abort, and the timeout counter. The round-robin pointer SHALL point to engine 0.
REQ-036 A reset during ROUTE SHALL abandon the packet without an abort pulse; in_ready SHALL be valid in the first cycle after reset.

Structure
REQ-037 The FSM state encoding, TMO_W default and queue depth SHALL live in package mrd_sched_pkg.
REQ-038 The order queue SHALL be a sub-module named mrd_sched_ordq, 1-bit data, 2 entries, push/pop/full/empty.
REQ-039 All outputs other than eng_sop, eng_valid and in_ready SHALL be registered.

Verification
REQ-040 Two back-to-back 64-sample packets, both engines ready -> eng_sel 0 then 1; queue holds [0,1]; out_sel = 0 until eng_src_eop[0], then 1.
REQ-041 Both eng_ready = 0, sop arrives -> in_ready = 0, drop_cnt = 1, FSM = BLOCK, no eng_sop; after eop, FSM returns to IDLE.
REQ-042 Sop with no eop for 4095 cycles (TMO_W = 12) -> eng_abort[sel] high for exactly 1 cycle, drop_cnt increments, queue unchanged.
REQ-043 Queue full [0,1] with a push and eng_src_eop[0] in the same cycle -> queue becomes [1,x], no loss, out_sel = 1.
REQ-044 eng_src_eop[1] while head = 0 -> queue unchanged.
REQ-045 Reset asserted mid-packet -> all outputs 0, in_ready = 1 with eng_ready = 2'b11 on the first cycle after reset.
